// File: rtl/si_pkg.sv
// Shared types and constants for the write-back scheduler slice.
package si_pkg;
   localparam int DEF_REG_AW = 5;
   localparam int DEF_REG_DW = 32;

   typedef struct packed {
      logic                  valid;
      logic [DEF_REG_AW-1:0] addr;
      logic [DEF_REG_DW-1:0] data;
   } wb_req_t;

   localparam logic [1:0] GNT_NONE = 2'd0;
   localparam logic [1:0] GNT_ALU  = 2'd1;
   localparam logic [1:0] GNT_LU   = 2'd2;
endpackage

// File: rtl/si_wb_sched_if.sv
// Issue, execute-unit and regfile write-port bundle of the scheduler.
interface si_wb_sched_if
   import si_pkg::*;
#(
   parameter int REG_AW = DEF_REG_AW,
   parameter int REG_DW = DEF_REG_DW
);
   logic              iss_valid_i;
   logic              iss_long_i;
   logic              iss_rd_en_i;
   logic [REG_AW-1:0] iss_rd_addr_i;
   logic              iss_rs1_en_i;
   logic [REG_AW-1:0] iss_rs1_addr_i;
   logic              iss_rs2_en_i;
   logic [REG_AW-1:0] iss_rs2_addr_i;
   logic              iss_stall_o;
   logic              alu_valid_i;
   logic [REG_AW-1:0] alu_addr_i;
   logic [REG_DW-1:0] alu_data_i;
   logic              alu_ready_o;
   logic              lu_valid_i;
   logic [REG_AW-1:0] lu_addr_i;
   logic [REG_DW-1:0] lu_data_i;
   logic              lu_ready_o;
   logic              wb_en_o;
   logic [REG_AW-1:0] wb_addr_o;
   logic [REG_DW-1:0] wb_data_o;
   logic [REG_AW:0]   busy_cnt_o;

   modport master (
      output iss_valid_i, iss_long_i, iss_rd_en_i, iss_rd_addr_i,
      output iss_rs1_en_i, iss_rs1_addr_i, iss_rs2_en_i, iss_rs2_addr_i,
      output alu_valid_i, alu_addr_i, alu_data_i,
      output lu_valid_i, lu_addr_i, lu_data_i,
      input  iss_stall_o, alu_ready_o, lu_ready_o,
      input  wb_en_o, wb_addr_o, wb_data_o, busy_cnt_o
   );

   modport slave (
      input  iss_valid_i, iss_long_i, iss_rd_en_i, iss_rd_addr_i,
      input  iss_rs1_en_i, iss_rs1_addr_i, iss_rs2_en_i, iss_rs2_addr_i,
      input  alu_valid_i, alu_addr_i, alu_data_i,
      input  lu_valid_i, lu_addr_i, lu_data_i,
      output iss_stall_o, alu_ready_o, lu_ready_o,
      output wb_en_o, wb_addr_o, wb_data_o, busy_cnt_o
   );
endinterface

// File: rtl/si_scoreboard.sv
// Busy-bit scoreboard for long-latency destinations with hazard lookup.
module si_scoreboard #(
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          set_en,
   input  logic [AW-1:0] set_addr,
   input  logic          clr_en,
   input  logic [AW-1:0] clr_addr,
   input  logic          rs1_en,
   input  logic [AW-1:0] rs1_addr,
   input  logic          rs2_en,
   input  logic [AW-1:0] rs2_addr,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic          hazard,
   output logic [AW:0]   busy_cnt
);
   localparam int N  = 2 ** AW;
   localparam int CW = AW + 1;

   logic [N-1:0] busy;
   logic         do_set;
   logic         do_clr;

   // Guarding on the current bit keeps the incremental count exact.
   assign do_set = set_en && (set_addr != '0) && !busy[set_addr];
   assign do_clr = clr_en && (clr_addr != '0) && busy[clr_addr];

   assign hazard = (rs1_en && busy[rs1_addr])
                || (rs2_en && busy[rs2_addr])
                || (rd_en && busy[rd_addr]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy     <= '0;
         busy_cnt <= '0;
      end else begin
         if (do_set) busy[set_addr] <= 1'b1;
         if (do_clr) busy[clr_addr] <= 1'b0;
         busy_cnt <= busy_cnt + CW'(do_set) - CW'(do_clr);
      end
   end
endmodule

// File: rtl/si_wb_sched.sv
// Write-back port arbiter (ALU vs long unit) with anti-starvation
// and registered regfile write.
module si_wb_sched
   import si_pkg::*;
#(
   parameter int REG_DW     = DEF_REG_DW,
   parameter int REG_AW     = DEF_REG_AW,
   parameter int STARVE_MAX = 4
) (
   input logic          clk,
   input logic          rst,
   si_wb_sched_if.slave bus
);
   localparam int SW = $clog2(STARVE_MAX + 1);

   logic [SW-1:0] starve_cnt;
   logic          force_lu;
   logic          hazard;
   logic          sb_set;
   logic [1:0]    gnt;
   wb_req_t       req;

   assign force_lu = bus.lu_valid_i && (starve_cnt == SW'(STARVE_MAX));
   assign bus.alu_ready_o = !force_lu;
   assign bus.lu_ready_o  = bus.lu_valid_i && (force_lu || !bus.alu_valid_i);
   assign bus.iss_stall_o = bus.iss_valid_i && hazard;

   assign sb_set = bus.iss_valid_i && bus.iss_long_i
                && bus.iss_rd_en_i && !bus.iss_stall_o;

   always_comb begin
      gnt = GNT_NONE;
      req = '0;
      unique case (1'b1)
         bus.lu_ready_o: begin
            gnt = GNT_LU;
            req = '{1'b1, bus.lu_addr_i, bus.lu_data_i};
         end
         (bus.alu_valid_i && bus.alu_ready_o): begin
            gnt = GNT_ALU;
            req = '{1'b1, bus.alu_addr_i, bus.alu_data_i};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt    <= '0;
         bus.wb_en_o   <= 1'b0;
         bus.wb_addr_o <= '0;
         bus.wb_data_o <= '0;
      end else begin
         if (!bus.lu_valid_i || gnt == GNT_LU)
            starve_cnt <= '0;
         else if (!force_lu)
            starve_cnt <= starve_cnt + 1'b1;
         bus.wb_en_o <= req.valid;
         if (req.valid) begin
            bus.wb_addr_o <= req.addr;
            bus.wb_data_o <= req.data;
         end
      end
   end

   si_scoreboard #(.AW(REG_AW)) u_sb (
      .clk      (clk),
      .rst      (rst),
      .set_en   (sb_set),
      .set_addr (bus.iss_rd_addr_i),
      .clr_en   (gnt == GNT_LU),
      .clr_addr (bus.lu_addr_i),
      .rs1_en   (bus.iss_rs1_en_i),
      .rs1_addr (bus.iss_rs1_addr_i),
      .rs2_en   (bus.iss_rs2_en_i),
      .rs2_addr (bus.iss_rs2_addr_i),
      .rd_en    (bus.iss_rd_en_i),
      .rd_addr  (bus.iss_rd_addr_i),
      .hazard   (hazard),
      .busy_cnt (bus.busy_cnt_o)
   );
endmodule
